contiguous_run_splitter: RTL and testbench
==========================================

Name: contiguous_run_splitter

Overview:
Iterative bit-run extractor that accepts a word and emits, one per cycle, a mask for each maximal contiguous run of 1 bits, starting from the LSB. It is built on the rightmost-bit manipulation identities (turn off rightmost contiguous 1s) and sits downstream of word-producing logic, feeding per-run consumers such as range/interval dispatchers. Ready/valid on both sides, with no bubble between words.

Parameters:
WORD_WIDTH, 8, width of input word and run masks; must be >= 1.
RUN_INDEX_WIDTH, 3, width of run ordinal; must hold ceil(WORD_WIDTH/2)-1; an elaboration-time check enforces this.

Ports:
clock  input  1  sole clock, rising edge.
clear_n  input  1  reset, asynchronous, active-low.
input_valid  input  1  input word offered.
input_ready  output  1  block can accept a word this cycle.
input_data  input  WORD_WIDTH  word to split.
output_valid  output  1  a run mask is presented.
output_ready  input  1  downstream accepts the run this cycle.
output_mask  output  WORD_WIDTH  1s exactly at the current run's bit positions.
output_index  output  RUN_INDEX_WIDTH  ordinal of the run within its word, starting at 0.
output_last  output  1  current run is the final run of its word.
output_empty  output  1  the word was all-zero; mask is 0.

Behaviour:
- State: remaining-word register R[WORD_WIDTH], index counter, empty flag, FSM {IDLE, EMIT}.
- Reset (clear_n low, asynchronous): FSM=IDLE, R=0, index=0, empty=0. While in reset: output_valid=0, output_mask=0, output_last=0, output_empty=0, output_index=0. input_ready=1 from the first cycle after release.
- Combinational per-cycle terms from R:
  - next_R = R & ((R | (R - 1)) + 1), which clears the lowest run. All arithmetic is modulo 2^WORD_WIDTH.
  - output_mask = R ^ next_R.
  - output_last = (next_R == 0).
- IDLE: output_valid=0, input_ready=1. On input_valid, load R=input_data, set index=0, set empty=(input_data==0), and go to EMIT.
- EMIT: output_valid=1. output_empty=empty. An empty word emits exactly one beat with mask=0, last=1, index=0.
- Output handshake (output_valid & output_ready):
  - If not last: R<=next_R, index<=index+1.
  - If last and input_valid: load the new word as in IDLE and stay in EMIT, with no bubble.
  - If last and no input_valid: go to IDLE.
- input_ready = IDLE | (EMIT & output_last & output_ready). This is a combinational path from output_ready; downstream must not make output_ready depend on input_ready.
- Without output_ready, all outputs and state hold stable; output_valid never drops until the beat is accepted.
- Latency: word accepted on edge N, first run visible after edge N. Steady-state throughput is one run per cycle.
- A word with k runs takes k beats (1 beat if zero).
- Boundaries:
  - All-ones word: single run, last=1.
  - MSB-terminated run: the +1 carry overflows to 0, giving next_R=0 and last=1.
  - WORD_WIDTH=1: word 1 gives a single run; word 0 gives an empty beat.
- input_data is ignored when input_ready=0.

Decomposition:
- Shared package:
  - FSM state typedef {IDLE, EMIT}.
  - Helper function for the minimum RUN_INDEX_WIDTH given WORD_WIDTH, used in the elaboration check.
- One natural sub-module: turn_off_rightmost_run (combinational, WORD_WIDTH parameter), producing next_R from R. The splitter instantiates it once; mask and last derive from its output.

Test Plan:
- WORD_WIDTH=8, input 8'b10100111, output_ready held 1 -> three consecutive beats:
  - mask 8'b00000111, idx 0, last 0.
  - mask 8'b00100000, idx 1, last 0.
  - mask 8'b10000000, idx 2, last 1.
  - Then IDLE.
- Input 8'h00 -> one beat: mask 0, idx 0, last 1, empty 1. Input 8'hFF -> one beat: mask 8'hFF, last 1, empty 0.
- Backpressure: input 8'b01100110, output_ready low 3 cycles -> mask 8'b00000110 is held stable with output_valid=1 and input_ready=0. After release, the next beat is 8'b01100000 with last 1.
- Back-to-back: while the last beat of 8'b10000000 is accepted, present 8'b01010101 with input_valid=1 -> input_ready=1 that cycle. Next cycle mask 8'b00000001 idx 0, followed by four runs idx 0..3 with no idle cycle.
- Reset mid-word: drive clear_n low during idx 1 of 8'b10100111 -> output_valid falls immediately (asynchronous). After release, IDLE with input_ready=1 and no residual runs. A new word 8'b00011000 yields a single beat, mask 8'b00011000, idx 0.

Source files
------------

// File: rtl/contiguous_run_splitter_pkg.sv
// Shared types and elaboration helpers for the contiguous run splitter.
package contiguous_run_splitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } splitter_state_e;

    // Bits needed to hold the largest run ordinal, ceil(w/2)-1 (at least 1 bit).
    function automatic int min_run_index_width(input int word_width);
        int max_ordinal;
        int width;
        max_ordinal = (word_width + 1) / 2 - 1;
        width = 1;
        while ((1 << width) <= max_ordinal) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/contiguous_run_splitter_turn_off_rightmost_run.sv
// Clears the lowest contiguous run of 1s in a word: r & ((r | (r - 1)) + 1).
module turn_off_rightmost_run #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] r,
    output logic [WORD_WIDTH-1:0] next_r
);

    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

    logic [WORD_WIDTH-1:0] fill_below;
    logic [WORD_WIDTH-1:0] carry_out;

    // Filling the zeros below the run lets the +1 carry ripple through it and
    // overflow to zero when the run reaches the MSB.
    assign fill_below = r | (r - ONE);
    assign carry_out  = fill_below + ONE;
    assign next_r     = r & carry_out;

endmodule

// File: rtl/contiguous_run_splitter.sv
// Splits each input word into one mask per contiguous run of 1s, LSB first,
// with ready/valid on both sides and no bubble between words.
module contiguous_run_splitter
    import contiguous_run_splitter_pkg::*;
#(
    parameter int WORD_WIDTH      = 8,
    parameter int RUN_INDEX_WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic                       input_valid,
    output logic                       input_ready,
    input  logic [WORD_WIDTH-1:0]      input_data,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic [WORD_WIDTH-1:0]      output_mask,
    output logic [RUN_INDEX_WIDTH-1:0] output_index,
    output logic                       output_last,
    output logic                       output_empty
);

    generate
        if (WORD_WIDTH < 1) begin : g_bad_word_width
            $error("contiguous_run_splitter: WORD_WIDTH must be >= 1");
        end
        if (RUN_INDEX_WIDTH < min_run_index_width(WORD_WIDTH)) begin : g_bad_index_width
            $error("contiguous_run_splitter: RUN_INDEX_WIDTH too narrow for WORD_WIDTH");
        end
    endgenerate

    localparam logic [RUN_INDEX_WIDTH-1:0] INDEX_ONE = RUN_INDEX_WIDTH'(1);

    splitter_state_e              state_q;
    splitter_state_e              state_d;
    logic [WORD_WIDTH-1:0]        remain_q;
    logic [WORD_WIDTH-1:0]        remain_next;
    logic [RUN_INDEX_WIDTH-1:0]   index_q;
    logic                         empty_q;
    logic                         emit;
    logic                         run_is_last;
    logic                         load;
    logic                         advance;

    turn_off_rightmost_run #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_turn_off (
        .r      (remain_q),
        .next_r (remain_next)
    );

    assign emit        = (state_q == EMIT);
    assign run_is_last = (remain_next == '0);
    assign load        = input_valid & input_ready;
    assign advance     = emit & output_ready & ~run_is_last;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (input_valid) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (output_ready && run_is_last) begin
                    state_d = input_valid ? EMIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to zero outside EMIT so stale remainder bits never leak.
    always_comb begin
        input_ready  = ~emit | (run_is_last & output_ready);
        output_valid = 1'b0;
        output_mask  = '0;
        output_index = '0;
        output_last  = 1'b0;
        output_empty = 1'b0;
        if (emit) begin
            output_valid = 1'b1;
            output_mask  = remain_q ^ remain_next;
            output_index = index_q;
            output_last  = run_is_last;
            output_empty = empty_q;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            remain_q <= '0;
            index_q  <= '0;
            empty_q  <= 1'b0;
        end else if (load) begin
            remain_q <= input_data;
            index_q  <= '0;
            empty_q  <= (input_data == '0);
        end else if (advance) begin
            remain_q <= remain_next;
            index_q  <= index_q + INDEX_ONE;
        end
    end

endmodule

// File: tb/tb_contiguous_run_splitter.sv
// Self-checking bench for contiguous_run_splitter: directed scenarios plus a
// randomized run against a bit-scanning reference model.
module tb_contiguous_run_splitter;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [W-1:0]  input_data = '0;
    logic          output_valid;
    logic          output_ready = 1'b0;
    logic [W-1:0]  output_mask;
    logic [IW-1:0] output_index;
    logic          output_last;
    logic          output_empty;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0]  mask;
        logic [IW-1:0] idx;
        logic          last;
        logic          empty;
    } beat_t;

    beat_t exp_q[$];

    contiguous_run_splitter #(
        .WORD_WIDTH      (W),
        .RUN_INDEX_WIDTH (IW)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_mask  (output_mask),
        .output_index (output_index),
        .output_last  (output_last),
        .output_empty (output_empty)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference model: scan bits LSB-first and emit one beat per maximal run of 1s.
    function automatic void push_word(input logic [W-1:0] word);
        logic [W-1:0] runs[W];
        int           n = 0;
        logic         in_run = 1'b0;
        beat_t        b;
        for (int i = 0; i < W; i++) begin
            if (word[i]) begin
                if (!in_run) begin
                    runs[n] = '0;
                    n++;
                end
                runs[n-1][i] = 1'b1;
                in_run = 1'b1;
            end else begin
                in_run = 1'b0;
            end
        end
        if (n == 0) begin
            b.mask = '0; b.idx = '0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                b.mask = runs[k]; b.idx = IW'(k); b.last = (k == n - 1); b.empty = 1'b0;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic test_reset();
        #2;
        total++;
        if ({output_valid, output_mask, output_index, output_last, output_empty} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b m=%h i=%0d l=%b e=%b required all 0",
                     output_valid, output_mask, output_index, output_last, output_empty);
        end
        cyc(); cyc();
        clear_n = 1'b1;
        #1;
        total++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ready=%b valid=%b required ready=1 valid=0",
                     input_ready, output_valid);
        end
        cyc();
    endtask

    task automatic test_multi_run();
        logic [W-1:0] m[3] = '{8'h07, 8'h20, 8'h80};
        input_valid = 1'b1; input_data = 8'b10100111; output_ready = 1'b1;
        #1;
        total++;
        if (input_ready !== 1'b1) begin
            bad++;
            $display("FAIL multi_accept got ready=%b required 1", input_ready);
        end
        cyc();
        input_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({output_valid, output_mask, output_index, output_last, output_empty} !==
                {1'b1, m[k], IW'(k), (k == 2), 1'b0}) begin
                bad++;
                $display("FAIL multi_beat%0d got v=%b m=%h i=%0d l=%b required m=%h i=%0d l=%b",
                         k, output_valid, output_mask, output_index, output_last, m[k], k, (k == 2));
            end
            cyc();
        end
        total++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            bad++;
            $display("FAIL multi_idle got valid=%b ready=%b required 0 1", output_valid, input_ready);
        end
    endtask

    task automatic test_empty_full();
        logic [W-1:0] words[2] = '{8'h00, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            input_valid = 1'b1; input_data = words[k]; output_ready = 1'b1;
            cyc();
            input_valid = 1'b0;
            #1;
            total++;
            if ({output_valid, output_mask, output_index, output_last, output_empty} !==
                {1'b1, words[k], IW'(0), 1'b1, (k == 0)}) begin
                bad++;
                $display("FAIL single_beat_%h got v=%b m=%h i=%0d l=%b e=%b required m=%h l=1 e=%b",
                         words[k], output_valid, output_mask, output_index, output_last,
                         output_empty, words[k], (k == 0));
            end
            cyc();
            total++;
            if (output_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_after_%h got valid=%b required 0", words[k], output_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        input_valid = 1'b1; input_data = 8'b01100110; output_ready = 1'b0;
        cyc();
        input_data = 8'hFF;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({output_valid, output_mask, output_index, output_last, input_ready} !==
                {1'b1, 8'h06, IW'(0), 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL stall%0d got v=%b m=%h i=%0d l=%b ready=%b required v=1 m=06 i=0 l=0 ready=0",
                         k, output_valid, output_mask, output_index, output_last, input_ready);
            end
            cyc();
        end
        input_valid = 1'b0; output_ready = 1'b1;
        #1;
        total++;
        if (output_mask !== 8'h06 || output_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got m=%h v=%b required m=06 v=1", output_mask, output_valid);
        end
        cyc();
        total++;
        if ({output_valid, output_mask, output_index, output_last} !== {1'b1, 8'h60, IW'(1), 1'b1}) begin
            bad++;
            $display("FAIL stall_second got v=%b m=%h i=%0d l=%b required m=60 i=1 l=1",
                     output_valid, output_mask, output_index, output_last);
        end
        cyc();
        total++;
        if (output_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle got valid=%b required 0 (ignored data loaded)", output_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m[4] = '{8'h01, 8'h04, 8'h10, 8'h40};
        input_valid = 1'b1; input_data = 8'b10000000; output_ready = 1'b1;
        cyc();
        input_data = 8'b01010101;
        #1;
        total++;
        if ({output_valid, output_mask, output_last, input_ready} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL b2b_handover got v=%b m=%h l=%b ready=%b required v=1 m=80 l=1 ready=1",
                     output_valid, output_mask, output_last, input_ready);
        end
        cyc();
        input_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({output_valid, output_mask, output_index, output_last} !== {1'b1, m[k], IW'(k), (k == 3)}) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b m=%h i=%0d l=%b required m=%h i=%0d",
                         k, output_valid, output_mask, output_index, output_last, m[k], k);
            end
            cyc();
        end
        total++;
        if (output_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got valid=%b required 0", output_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        input_valid = 1'b1; input_data = 8'b10100111; output_ready = 1'b1;
        cyc();
        input_valid = 1'b0;
        cyc();
        output_ready = 1'b0;
        #1;
        total++;
        if (output_index !== IW'(1) || output_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got i=%0d v=%b required i=1 v=1", output_index, output_valid);
        end
        clear_n = 1'b0;
        #1;
        total++;
        if (output_valid !== 1'b0 || output_mask !== '0) begin
            bad++;
            $display("FAIL midrst_async got v=%b m=%h required v=0 m=00", output_valid, output_mask);
        end
        cyc(); cyc();
        clear_n = 1'b1;
        output_ready = 1'b1;
        cyc();
        total++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_idle got v=%b ready=%b required v=0 ready=1", output_valid, input_ready);
        end
        input_valid = 1'b1; input_data = 8'b00011000;
        cyc();
        input_valid = 1'b0;
        #1;
        total++;
        if ({output_valid, output_mask, output_index, output_last} !== {1'b1, 8'h18, IW'(0), 1'b1}) begin
            bad++;
            $display("FAIL midrst_new got v=%b m=%h i=%0d l=%b required m=18 i=0 l=1",
                     output_valid, output_mask, output_index, output_last);
        end
        cyc();
    endtask

    task automatic test_random();
        localparam int NWORDS = 300;
        int           widx = 0;
        int           cycles = 0;
        logic         pend = 1'b0;
        logic [W-1:0] cur = '0;
        logic         exp_ready;
        beat_t        f;
        exp_q.delete();
        while ((widx < NWORDS || exp_q.size() != 0) && cycles < 5000) begin
            if (!pend && widx < NWORDS && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                case ($urandom_range(0, 5))
                    0:       cur = 8'h00;
                    1:       cur = 8'hFF;
                    2:       cur = 8'h55;
                    default: cur = W'($urandom);
                endcase
            end
            input_valid  = pend;
            input_data   = pend ? cur : W'($urandom);
            output_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (exp_q.size() == 0) || (exp_q[0].last && output_ready);
            total++;
            if (input_ready !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d got %b required %b", cycles, input_ready, exp_ready);
            end
            total++;
            if (exp_q.size() == 0) begin
                if (output_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle cyc=%0d got valid=%b required 0", cycles, output_valid);
                end
            end else begin
                f = exp_q[0];
                if ({output_valid, output_mask, output_index, output_last, output_empty} !==
                    {1'b1, f.mask, f.idx, f.last, f.empty}) begin
                    bad++;
                    $display("FAIL rand_beat cyc=%0d got v=%b m=%h i=%0d l=%b e=%b required m=%h i=%0d l=%b e=%b",
                             cycles, output_valid, output_mask, output_index, output_last, output_empty,
                             f.mask, f.idx, f.last, f.empty);
                end
                if (output_ready) void'(exp_q.pop_front());
            end
            if (pend && exp_ready) begin
                push_word(cur);
                pend = 1'b0;
                widx++;
            end
            cycles++;
            @(posedge clock);
            #1;
        end
        input_valid = 1'b0;
        total++;
        if (cycles >= 5000) begin
            bad++;
            $display("FAIL rand_timeout got words=%0d pending=%0d required all drained", widx, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_multi_run();
        test_empty_full();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
